// File: rtl/nbout_pkg.sv
// Shared definitions for the nbout drain engine: drain FSM encoding,
// default geometry and a row-counter width helper.
package nbout_pkg;

    localparam int N_DEF         = 16;
    localparam int TN_DEF        = 16;
    localparam int ADDR_SIZE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    // Width of a counter indexing 0..tn-1, never narrower than one bit.
    function automatic int row_w(input int tn);
        return (tn > 1) ? $clog2(tn) : 1;
    endfunction

endpackage

// File: rtl/nbout_drain_if.sv
// Buffer read port plus outbound row stream of the nbout drain engine.
interface nbout_drain_if
    import nbout_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int Tn        = TN_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    logic                    o_rd_en;
    logic [ADDR_SIZE-1:0]    o_rd_addr;
    logic [Tn*Tn*N-1:0]      i_rd_data;
    logic [Tn*N-1:0]         o_data;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_last;

    modport master (
        output o_rd_en, o_rd_addr, o_data, o_valid, o_last,
        input  i_rd_data, i_ready
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_data, o_valid, o_last,
        output i_rd_data, i_ready
    );
endinterface

// File: rtl/nbout_row_mux.sv
// Selects one Tn*N-bit row out of a captured Tn-row buffer entry.
module nbout_row_mux #(
    parameter int N     = 16,
    parameter int Tn    = 16,
    parameter int ROW_W = 4
) (
    input  logic [Tn*Tn*N-1:0] entry,
    input  logic [ROW_W-1:0]   row,
    output logic [Tn*N-1:0]    data
);
    logic [Tn-1:0][Tn*N-1:0] rows;

    assign rows = entry;
    assign data = rows[row];
endmodule

// File: rtl/nbout_drain.sv
// Drains buffer entries 0..last: read, capture, then stream Tn rows with
// valid/ready backpressure; pulses done after the final row handshake.
module nbout_drain
    import nbout_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int Tn        = TN_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [ADDR_SIZE-1:0] i_last_addr,
    output logic                 o_busy,
    output logic                 o_done,
    nbout_drain_if.master        bus
);
    localparam int ROW_W = row_w(Tn);

    state_t               state, state_nx;
    logic [ADDR_SIZE-1:0] addr, last_addr;
    logic [ROW_W-1:0]     row;
    logic [Tn*Tn*N-1:0]   entry;
    logic                 done;
    logic                 xfer, row_end, addr_end;

    assign xfer     = (state == SEND) && bus.i_ready;
    assign row_end  = (row == ROW_W'(Tn - 1));
    assign addr_end = (addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = RD;
            RD:      state_nx = CAP;
            CAP:     state_nx = SEND;
            SEND:    if (xfer && row_end) state_nx = addr_end ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    // Address only advances when more entries remain, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            last_addr <= '0;
            row       <= '0;
            entry     <= '0;
            done      <= 1'b0;
        end else begin
            done <= xfer && row_end && addr_end;
            case (state)
                IDLE: if (i_start) begin
                    last_addr <= i_last_addr;
                    addr      <= '0;
                    row       <= '0;
                end
                CAP:  entry <= bus.i_rd_data;
                SEND: if (xfer) begin
                    if (row_end) begin
                        row <= '0;
                        if (!addr_end) addr <= addr + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    nbout_row_mux #(.N(N), .Tn(Tn), .ROW_W(ROW_W)) u_row_mux (
        .entry (entry),
        .row   (row),
        .data  (bus.o_data)
    );

    assign bus.o_rd_en   = (state == RD);
    assign bus.o_rd_addr = addr;
    assign bus.o_valid   = (state == SEND);
    assign bus.o_last    = (state == SEND) && row_end && addr_end;
    assign o_busy        = (state != IDLE);
    assign o_done        = done;
endmodule

// File: doc/nbout_drain.md
NBOUT_DRAIN -- requirements
Module: nbout_drain

Interface
REQ-001 Parameter N, default 16, bit width of one output neuron value.
REQ-002 Parameter Tn, default 16, neurons per row; one buffer entry holds Tn rows.
REQ-003 Parameter ADDR_SIZE, default 4, nbout buffer address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  one-cycle request to drain entries 0..i_last_addr.
REQ-007 i_last_addr  input  ADDR_SIZE  last buffer address to drain; sampled only when i_start is accepted.
REQ-008 o_rd_en  output  1  buffer read strobe.
REQ-009 o_rd_addr  output  ADDR_SIZE  buffer read address.
REQ-010 i_rd_data  input  Tn*Tn*N  buffer read data, valid exactly one cycle after o_rd_en.
REQ-011 o_data  output  Tn*N  one row of output neurons.
REQ-012 o_valid  output  1  o_data valid.
REQ-013 i_ready  input  1  downstream accepts o_data.
REQ-014 o_last  output  1  high with the final row of the final entry.
REQ-015 o_busy  output  1  high whenever state is not IDLE.
REQ-016 o_done  output  1  one-cycle pulse the cycle after the final row handshake.

Function
REQ-017 FSM states SHALL be IDLE, RD, CAP, SEND.
REQ-018 IDLE: i_start=1 latches i_last_addr, clears address and row counters, next state RD; i_start while not IDLE is ignored.
REQ-019 RD: o_rd_en=1, o_rd_addr=current address for exactly one cycle; next state CAP.
REQ-020 CAP: i_rd_data captured into the entry register; next state SEND.
REQ-021 SEND: o_valid=1, o_data = entry register bits [(r+1)*Tn*N-1 : r*Tn*N] for row counter r, row 0 first.
REQ-022 A beat transfers when o_valid and i_ready are both 1 in the same cycle; the row counter advances only on a transfer.
REQ-023 While o_valid=1 and i_ready=0, o_data, o_last, and the row counter SHALL hold stable.
REQ-024 Transfer with r=Tn-1 and address<last: address+1, r=0, next state RD.
REQ-025 Transfer with r=Tn-1 and address==last: next state IDLE; o_done=1 in the following cycle.
REQ-026 o_last = SEND and r==Tn-1 and address==last.
REQ-027 o_rd_en, o_valid, o_last are 0 outside RD/SEND respectively; o_rd_addr holds the current address in all states.
REQ-028 With i_ready held 1, each entry SHALL take Tn+2 cycles; start-to-first-o_valid latency SHALL be 3 cycles.
REQ-029 i_last_addr = 2^ADDR_SIZE-1 SHALL drain all entries without address wrap; the address counter never wraps mid-drain.
REQ-030 i_rd_data is ignored in all states except CAP.

Reset
REQ-031 rst=1 SHALL force IDLE, clear counters and entry register, drive o_rd_en, o_valid, o_last, o_busy, o_done, o_rd_addr, o_data to 0 on the next edge.
REQ-032 rst asserted mid-drain SHALL abort without further reads, beats, or o_done; rst has priority over i_start.

Structure
REQ-033 State encoding and default N/Tn/ADDR_SIZE SHALL live in shared package nbout_pkg.
REQ-034 Row selection SHALL be isolated in sub-module nbout_row_mux (entry register, row index -> Tn*N row); FSM and counters stay in nbout_drain.

Verification (bench parameters N=4, Tn=2, ADDR_SIZE=2 unless stated)
REQ-035 i_last_addr=0, i_rd_data=16'hABCD, i_ready=1 -> o_rd_en/addr 0 at cycle 1, o_data 8'hCD at cycle 3, 8'hAB with o_last at cycle 4, o_done at cycle 5.
REQ-036 i_last_addr=3, i_ready=1 -> reads at addresses 0,1,2,3 spaced 4 cycles apart, 8 beats total, single o_done.
REQ-037 Backpressure: i_ready=0 for 5 cycles during row 1 -> o_data/o_last stable, no extra beat, row 1 delivered once.
REQ-038 i_start pulsed while busy with i_last_addr=0 during a 3-entry drain -> ignored, drain completes 3 entries.
REQ-039 rst asserted during SEND of entry 1 -> next cycle all outputs 0, o_busy=0, no o_done; subsequent i_start drains from address 0.
REQ-040 Defaults (N=16, Tn=16), i_last_addr=15 -> 256 beats, 16 reads, addresses 0..15 in order, no wrap.
